// File: rtl/mem_stage_if.sv
// Data-memory handshake bundle between the MEM stage (master) and the memory (slave).
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction bundle, runs the data-memory
// handshake for loads/stores with a timeout, and feeds the forwarding unit.
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_ex_valid,
    input  logic [3:0]  i_ex_op1,
    input  logic [3:0]  i_ex_op2,
    input  logic [15:0] i_ex_res1,
    input  logic [15:0] i_ex_res2,
    input  logic [15:0] i_ex_r15,
    input  logic [1:0]  i_ex_rwrite,
    input  logic        i_ex_memread,
    input  logic        i_ex_memwrite,
    input  logic [15:0] i_ex_addr,
    input  logic [15:0] i_ex_sdata,

    output logic [3:0]  o_memop1,
    output logic [3:0]  o_memop2,
    output logic [15:0] o_memop1data,
    output logic [15:0] o_memop2data,
    output logic [15:0] o_memr15data,
    output logic [1:0]  o_rwrite,
    output logic        o_stall,
    output logic        o_mem_err,

    mem_stage_if.master dmem
);

    // state  | meaning
    // IDLE   | accept a new instruction from EX every cycle
    // ACCESS | memory request outstanding, EX and earlier frozen
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_op1;
    logic [3:0]  r_op2;
    logic [15:0] r_res1;
    logic [15:0] r_res2;
    logic [15:0] r_r15;
    logic [1:0]  r_rwrite;
    logic        r_memread;
    logic        r_memwrite;
    logic [15:0] r_addr;
    logic [15:0] r_sdata;
    logic [7:0]  r_cnt;
    logic        r_err;

    logic        w_capture;
    logic        w_is_mem;
    logic        w_ack_done;
    logic        w_timeout;
    logic        w_access;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_ack_done = 1'b0;
        w_timeout  = 1'b0;
        w_is_mem   = i_ex_memread | i_ex_memwrite;
        case (r_state)
            S_IDLE: begin
                w_capture = i_ex_valid;
                if (i_ex_valid && w_is_mem) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // ack on the final allowed cycle still completes normally
                if (dmem.ack) begin
                    w_ack_done = 1'b1;
                    w_next     = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op1      <= 4'd0;
            r_op2      <= 4'd0;
            r_res1     <= 16'd0;
            r_res2     <= 16'd0;
            r_r15      <= 16'd0;
            r_rwrite   <= 2'd0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_addr     <= 16'd0;
            r_sdata    <= 16'd0;
            r_cnt      <= 8'd0;
            r_err      <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_capture) begin
                r_op1      <= i_ex_op1;
                r_op2      <= i_ex_op2;
                r_res1     <= i_ex_res1;
                r_res2     <= i_ex_res2;
                r_r15      <= i_ex_r15;
                r_rwrite   <= i_ex_rwrite;
                r_memread  <= i_ex_memread;
                r_memwrite <= i_ex_memwrite;
                r_addr     <= i_ex_addr;
                r_sdata    <= i_ex_sdata;
                r_cnt      <= 8'd0;
            end else begin
                r_rwrite <= 2'd0;
            end
        end else begin
            if (w_ack_done) begin
                if (r_memread) begin
                    r_res1 <= dmem.rdata;
                end
            end else if (w_timeout) begin
                r_err    <= 1'b1;
                r_rwrite <= 2'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign w_access     = (r_state == S_ACCESS);

    assign o_memop1     = r_op1;
    assign o_memop2     = r_op2;
    assign o_memop1data = r_res1;
    assign o_memop2data = r_res2;
    assign o_memr15data = r_r15;
    // load data is not ready while waiting, so hide the write-back from forwarding
    assign o_rwrite     = (w_access && r_memread) ? 2'd0 : r_rwrite;
    assign o_stall      = w_access;
    assign o_mem_err    = r_err;

    assign dmem.req     = w_access;
    assign dmem.we      = w_access & r_memwrite;
    assign dmem.addr    = r_addr;
    assign dmem.wdata   = r_sdata;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// instruction stream checked against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_stage;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_op1, ex_op2;
    logic [15:0] ex_res1, ex_res2, ex_r15;
    logic [1:0]  ex_rw;
    logic        ex_rd, ex_wr;
    logic [15:0] ex_addr, ex_sdata;
    logic [3:0]  memop1, memop2;
    logic [15:0] d1, d2, d15;
    logic [1:0]  rw;
    logic        stall, err;

    mem_stage_if dmem_bus ();

    mem_stage #(.TIMEOUT(TO)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ex_valid    (ex_valid),
        .i_ex_op1      (ex_op1),
        .i_ex_op2      (ex_op2),
        .i_ex_res1     (ex_res1),
        .i_ex_res2     (ex_res2),
        .i_ex_r15      (ex_r15),
        .i_ex_rwrite   (ex_rw),
        .i_ex_memread  (ex_rd),
        .i_ex_memwrite (ex_wr),
        .i_ex_addr     (ex_addr),
        .i_ex_sdata    (ex_sdata),
        .o_memop1      (memop1),
        .o_memop2      (memop2),
        .o_memop1data  (d1),
        .o_memop2data  (d2),
        .o_memr15data  (d15),
        .o_rwrite      (rw),
        .o_stall       (stall),
        .o_mem_err     (err),
        .dmem          (dmem_bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model of what MEM currently holds / shows
    logic [3:0]  m_op1, m_op2;
    logic [15:0] m_d1, m_d2, m_d15, m_addr, m_sdata;
    logic [1:0]  m_rw;
    logic        m_rd, m_wr, m_err, m_busy;

    logic [61:0] obs, exp_v;
    assign obs = {memop1, memop2, d1, d2, d15, rw, stall, err, dmem_bus.req, dmem_bus.we};

    function automatic logic [61:0] expect_vec();
        logic [1:0] vis_rw;
        vis_rw = (m_busy && m_rd) ? 2'b00 : m_rw;
        return {m_op1, m_op2, m_d1, m_d2, m_d15, vis_rw, m_busy, m_err, m_busy, m_busy & m_wr};
    endfunction

    task automatic model_reset();
        m_op1 = 0; m_op2 = 0; m_d1 = 0; m_d2 = 0; m_d15 = 0; m_rw = 0;
        m_rd = 0; m_wr = 0; m_err = 0; m_busy = 0; m_addr = 0; m_sdata = 0;
    endtask

    // instruction presented while MEM is free: take it, or drop write-back on a bubble
    task automatic model_issue();
        if (ex_valid) begin
            m_op1 = ex_op1; m_op2 = ex_op2; m_d1 = ex_res1; m_d2 = ex_res2; m_d15 = ex_r15;
            m_rw = ex_rw; m_rd = ex_rd; m_wr = ex_wr; m_addr = ex_addr; m_sdata = ex_sdata;
            m_busy = ex_rd | ex_wr;
        end else begin
            m_rw = 2'b00;
        end
    endtask

    task automatic model_ack(input logic [15:0] v);
        if (m_rd) m_d1 = v;
        m_busy = 1'b0;
    endtask

    task automatic model_timeout();
        m_err = 1'b1; m_rw = 2'b00; m_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [3:0] o1, input logic [3:0] o2,
                          input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] r15,
                          input logic [1:0] w, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] s);
        ex_valid = v; ex_op1 = o1; ex_op2 = o2; ex_res1 = r1; ex_res2 = r2; ex_r15 = r15;
        ex_rw = w; ex_rd = rd; ex_wr = wr; ex_addr = a; ex_sdata = s;
    endtask

    task automatic junk_ex();
        logic rd;
        rd = 1'($urandom_range(0, 1));
        set_ex(1'b1, 4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               2'($urandom), rd, ~rd & 1'($urandom), 16'($urandom), 16'($urandom));
        dmem_bus.rdata = 16'($urandom);
    endtask

    task automatic test_reset();
        dmem_bus.ack = 1'b0;
        junk_ex();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_state: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_alu();
        set_ex(1, 4'd5, 4'd0, 16'hAAAA, 16'h0, 16'h0, 2'd1, 0, 0, 16'h0, 16'h0);
        model_issue();
        tick();
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL alu_fwd: got %h expected %h", obs, exp_v); end
        set_ex(0, 4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               2'd3, 0, 0, 16'($urandom), 16'($urandom));
        model_issue();
        tick();
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL bubble_rw0: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_load();
        set_ex(1, 4'd6, 4'd1, 16'h1111, 16'h2222, 16'h3333, 2'd1, 1, 0, 16'h0010, 16'h0);
        model_issue();
        tick();
        for (int k = 1; k <= 3; k++) begin
            exp_v = expect_vec();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL load_wait%0d: got %h expected %h", k, obs, exp_v); end
            n_tests++;
            if (dmem_bus.addr !== 16'h0010) begin n_fail++; $display("FAIL load_addr: got %h expected 0010", dmem_bus.addr); end
            junk_ex();
            if (k == 3) begin dmem_bus.ack = 1'b1; dmem_bus.rdata = 16'hBBBB; end
            tick();
            dmem_bus.ack = 1'b0;
        end
        model_ack(16'hBBBB);
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL load_done: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_store();
        set_ex(1, 4'd7, 4'd8, 16'h5555, 16'h6666, 16'h7777, 2'd0, 0, 1, 16'h0020, 16'h1234);
        model_issue();
        tick();
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL store_access: got %h expected %h", obs, exp_v); end
        n_tests++;
        if ({dmem_bus.addr, dmem_bus.wdata} !== 32'h0020_1234) begin
            n_fail++; $display("FAIL store_bus: got %h expected 00201234", {dmem_bus.addr, dmem_bus.wdata});
        end
        junk_ex();
        dmem_bus.ack = 1'b1;
        tick();
        dmem_bus.ack = 1'b0;
        model_ack(16'h0);
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL store_done: got %h expected %h", obs, exp_v); end
        model_issue();
        tick();
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL store_we_once: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_r15();
        set_ex(1, 4'd2, 4'd9, 16'h0001, 16'($urandom), 16'hFFFF, 2'd3, 0, 0, 16'h0, 16'h0);
        model_issue();
        tick();
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL r15_fwd: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_ack_idle();
        set_ex(1, 4'd3, 4'd4, 16'hC0DE, 16'hBEEF, 16'hFACE, 2'd2, 0, 0, 16'h0, 16'h0);
        model_issue();
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dmem_bus.ack = 1'b1;
        dmem_bus.rdata = 16'h9999;
        model_issue();
        tick();
        dmem_bus.ack = 1'b0;
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL ack_idle: got %h expected %h", obs, exp_v); end
    endtask

    // load with ack on cycle lat (lat > TO means no ack at all)
    task automatic run_load(input int lat, input logic [15:0] v);
        set_ex(1, 4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               2'd1, 1, 0, 16'($urandom), 16'($urandom));
        model_issue();
        tick();
        for (int k = 1; k <= TO; k++) begin
            exp_v = expect_vec();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL to_wait%0d: got %h expected %h", k, obs, exp_v); end
            junk_ex();
            if (k == lat) begin dmem_bus.ack = 1'b1; dmem_bus.rdata = v; end
            tick();
            dmem_bus.ack = 1'b0;
            if (k == lat) begin model_ack(v); break; end
            if (k == TO) model_timeout();
        end
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        run_load(TO + 1, 16'h0);
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL to_err: got %h expected %h", obs, exp_v); end
        set_ex(1, 4'd1, 4'd1, 16'h4242, 16'h0, 16'h0, 2'd1, 0, 0, 16'h0, 16'h0);
        model_issue();
        tick();
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL err_sticky: got %h expected %h", obs, exp_v); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL err_clear: got %h expected %h", obs, exp_v); end
        run_load(TO, 16'h5A5A);
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL to_ack_wins: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid();
        set_ex(1, 4'd6, 4'd2, 16'h1357, 16'h2468, 16'h9ABC, 2'd3, 1, 0, 16'h0040, 16'h0);
        model_issue();
        tick();
        junk_ex();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        exp_v = expect_vec();
        n_tests++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_mid: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int kind;
            int lat;
            logic [15:0] v;
            kind = $urandom_range(0, 3);
            set_ex(kind != 3, 4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   2'($urandom), kind == 1, kind == 2, 16'($urandom), 16'($urandom));
            model_issue();
            tick();
            exp_v = expect_vec();
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL rnd_issue%0d: got %h expected %h", i, obs, exp_v); end
            if (kind == 1 || kind == 2) begin
                lat = $urandom_range(1, TO + 3);
                v = 16'($urandom);
                for (int k = 1; k <= TO; k++) begin
                    n_tests++;
                    if ({dmem_bus.addr, dmem_bus.wdata} !== {m_addr, m_sdata}) begin
                        n_fail++;
                        $display("FAIL rnd_bus%0d: got %h expected %h", i, {dmem_bus.addr, dmem_bus.wdata}, {m_addr, m_sdata});
                    end
                    junk_ex();
                    if (k == lat) begin dmem_bus.ack = 1'b1; dmem_bus.rdata = v; end
                    tick();
                    dmem_bus.ack = 1'b0;
                    if (k == lat) begin model_ack(v); break; end
                    if (k == TO) model_timeout();
                    exp_v = expect_vec();
                    n_tests++;
                    if (obs !== exp_v) begin n_fail++; $display("FAIL rnd_wait%0d: got %h expected %h", i, obs, exp_v); end
                end
                exp_v = expect_vec();
                n_tests++;
                if (obs !== exp_v) begin n_fail++; $display("FAIL rnd_done%0d: got %h expected %h", i, obs, exp_v); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        dmem_bus.ack = 1'b0;
        dmem_bus.rdata = 16'h0;
        model_reset();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_r15();
        test_ack_idle();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
